// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide controller.
package muldiv_pkg;
  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MTHI  = 2'b10,
    OP_MTLO  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;
endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the pipeline (master) and muldiv_ctl (slave).
interface muldiv_if #(parameter int WIDTH = 32);
  import muldiv_pkg::*;

  logic             start;
  op_e              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_dp.sv
// One iteration of unsigned shift-add multiply or restoring divide.
// The divide path exists only when MULDIV_DIV_EN is defined.
module muldiv_dp
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  logic [WIDTH:0] w_sum;

  // Multiply step: add b when the current multiplier bit is set, then shift right.
  always_comb begin
    w_sum = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : {(WIDTH+1){1'b0}});
  end

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  // Divide step: shift the next dividend bit into the remainder and try to subtract b.
  // With b=0 the subtract always succeeds, leaving quotient all ones and remainder a.
  always_comb begin
    w_shift = {i_hi, i_lo[WIDTH-1]};
    w_diff  = w_shift - {1'b0, i_b};
    w_ge    = (w_shift >= {1'b0, i_b});
    if (i_div) begin
      o_hi = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
      o_lo = {i_lo[WIDTH-2:0], w_ge};
    end else begin
      o_hi = w_sum[WIDTH:1];
      o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
    end
  end
`else
  // Multiply-only build; a divide request never reaches RUN, so i_div simply holds.
  always_comb begin
    if (i_div) begin
      o_hi = i_hi;
      o_lo = i_lo;
    end else begin
      o_hi = w_sum[WIDTH:1];
      o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
    end
  end
`endif
endmodule

// File: rtl/muldiv_ctl.sv
// Multi-cycle MULTU/DIVU controller owning HI/LO, FSM and iteration counter.
// Define MULDIV_DIV_EN to build the divider; otherwise DIVU requests are ignored.
module muldiv_ctl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     i_clk,
  input  logic     i_rst,
  muldiv_if.slave  bus
);
  localparam int                CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  state_e             r_state;
  state_e             w_next;
  logic               w_accept;
  logic               w_div_req;
  logic               w_last;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_div;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [WIDTH-1:0]   r_acc_lo;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   w_dp_hi;
  logic [WIDTH-1:0]   w_dp_lo;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

`ifdef MULDIV_DIV_EN
  assign w_div_req = (bus.op == OP_DIVU);
`else
  assign w_div_req = 1'b0;
`endif

  assign w_last = (r_cnt == LAST);

  // Next-state: only IDLE accepts work; DONE always falls back to IDLE.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start && ((bus.op == OP_MULTU) || w_div_req)) begin
          w_next   = ST_RUN;
          w_accept = 1'b1;
        end else begin
          w_next   = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_next = ST_DONE;
        end else begin
          w_next = ST_RUN;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State register with registered busy/done derived from the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == ST_RUN);
      r_done  <= (w_next == ST_DONE);
    end
  end

  // Working registers: operands latched on accept, one iteration per RUN cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_div    <= 1'b0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_b      <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_div    <= (bus.op == OP_DIVU);
      r_acc_hi <= '0;
      r_acc_lo <= bus.a;
      r_b      <= bus.b;
    end else if (r_state == ST_RUN) begin
      r_cnt    <= r_cnt + CNT_W'(1);
      r_acc_hi <= w_dp_hi;
      r_acc_lo <= w_dp_lo;
    end
  end

  muldiv_dp #(.WIDTH(WIDTH)) u_dp (
    .i_div (r_div),
    .i_hi  (r_acc_hi),
    .i_lo  (r_acc_lo),
    .i_b   (r_b),
    .o_hi  (w_dp_hi),
    .o_lo  (w_dp_lo)
  );

  // HI/LO change only on the final iteration or on an MTHI/MTLO accepted in IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if ((r_state == ST_RUN) && w_last) begin
      r_hi <= w_dp_hi;
      r_lo <= w_dp_lo;
    end else if ((r_state == ST_IDLE) && bus.start && (bus.op == OP_MTHI)) begin
      r_hi <= bus.a;
    end else if ((r_state == ST_IDLE) && bus.start && (bus.op == OP_MTLO)) begin
      r_lo <= bus.a;
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule
